// File: rtl/ascon_pack.sv
// Shared Ascon definitions used by the permutation datapath.
//
// Contents:
//   type_state     - 5 x 64-bit permutation state, index 0..4 = x0..x4
//   round_constant - 8-bit round constant c(r) for round index r
//   ROUNDS_PA/PB   - round counts for the p^a and p^b permutations
package ascon_pack;

  localparam int NUM_WORDS = 5;
  localparam int WORD_W    = 64;
  localparam int ROUND_W   = 4;

  // p^a runs rounds 0..11, p^b runs the last six (6..11).
  localparam int ROUNDS_PA = 12;
  localparam int ROUNDS_PB = 6;

  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] type_state;

  // c(r) = {F - r, r} for the twelve defined rounds. Indices 12..15 return
  // zero, so an out-of-range round leaves the state untouched.
  function automatic logic [7:0] round_constant(input logic [ROUND_W-1:0] r);
    logic [3:0] hi;
    logic [7:0] c;
    hi = 4'hF - r;
    c  = 8'h00;
    if (r < 4'(ROUNDS_PA)) begin
      c = {hi, r};
    end
    return c;
  endfunction

endpackage

// File: rtl/constant_addition.sv
// Ascon constant-addition layer p_C, registered.
// XORs the round constant into the low byte of x2; all other bits of the
// state are copied through. The result is captured on a rising clock edge
// when en_i is high and held otherwise.
//
// Ports:
//   clock_i   - system clock, rising edge active
//   resetb_i  - asynchronous active-low reset, clears state_o
//   en_i      - capture enable
//   round_i   - round index 0..15 selecting the constant
//   state_i   - input state x0..x4
//   state_o   - registered output state
module constant_addition
  import ascon_pack::*;
(
  input  logic               clock_i,
  input  logic               resetb_i,
  input  logic               en_i,
  input  logic [ROUND_W-1:0] round_i,
  input  type_state          state_i,
  output type_state          state_o
);

  type_state state_d;
  type_state state_q;

  // Only bits [7:0] of x2 are touched; when disabled the register
  // recirculates its current value.
  always_comb begin
    state_d = state_q;
    if (en_i) begin
      state_d       = state_i;
      state_d[2][7:0] = state_i[2][7:0] ^ round_constant(round_i);
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_constant_addition.sv
// Directed self-checking bench for constant_addition.
module tb_constant_addition;
  import ascon_pack::*;

  logic               clock_i;
  logic               resetb_i;
  logic               en_i;
  logic [ROUND_W-1:0] round_i;
  type_state          state_i;
  type_state          state_o;

  int checks;
  int failures;

  type_state base;

  constant_addition dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .en_i     (en_i),
    .round_i  (round_i),
    .state_i  (state_i),
    .state_o  (state_o)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  // Inputs change on the falling edge; outputs are sampled on the falling
  // edge following the capturing rising edge.
  task automatic step();
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic test_reset();
    resetb_i = 1'b0;
    en_i     = 1'b1;
    round_i  = 4'd0;
    state_i  = base;
    #1;
    for (int k = 0; k < NUM_WORDS; k++) begin
      checks++;
      if (state_o[k] !== 64'h0) begin
        failures++;
        $display("[TB] FAIL reset_async word%0d got=%h want=%h", k, state_o[k], 64'h0);
      end
    end
    step();
    step();
    checks++;
    if (state_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_held got=%h want=0", state_o);
    end
    en_i     = 1'b0;
    resetb_i = 1'b1;
    step();
    step();
    checks++;
    if (state_o !== '0) begin
      failures++;
      $display("[TB] FAIL reset_release_en0 got=%h want=0", state_o);
    end
  endtask

  task automatic test_rounds();
    logic [3:0]  rounds [3];
    logic [63:0] want_x2 [3];
    type_state   want;
    rounds  = '{4'd0, 4'd6, 4'd11};
    want_x2 = '{64'hbe263d4d7aecaa0f, 64'hbe263d4d7aecaa69, 64'hbe263d4d7aecaab4};
    for (int i = 0; i < 3; i++) begin
      state_i = base;
      round_i = rounds[i];
      en_i    = 1'b1;
      step();
      want    = base;
      want[2] = want_x2[i];
      checks++;
      if (state_o !== want) begin
        failures++;
        $display("[TB] FAIL round%0d got=%h want=%h", rounds[i], state_o, want);
      end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] rounds [2];
    rounds = '{4'd12, 4'd15};
    for (int i = 0; i < 2; i++) begin
      state_i = base;
      round_i = rounds[i];
      en_i    = 1'b1;
      step();
      checks++;
      if (state_o !== base) begin
        failures++;
        $display("[TB] FAIL out_of_range%0d got=%h want=%h", rounds[i], state_o, base);
      end
    end
  endtask

  task automatic test_enable_hold();
    type_state want;
    state_i = base;
    round_i = 4'd0;
    en_i    = 1'b1;
    step();
    want    = base;
    want[2] = 64'hbe263d4d7aecaa0f;
    state_i = ~base;
    round_i = 4'd3;
    en_i    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (state_o !== want) begin
        failures++;
        $display("[TB] FAIL enable_hold cycle%0d got=%h want=%h", i, state_o, want);
      end
    end
    en_i = 1'b1;
    step();
    want    = ~base;
    want[2] = 64'h41d9c2b2851355c3;
    checks++;
    if (state_o !== want) begin
      failures++;
      $display("[TB] FAIL enable_capture got=%h want=%h", state_o, want);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_c [12];
    type_state  s;
    exp_c = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
              8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B};
    s    = base;
    s[2] = 64'h0;
    for (int r = 0; r < 12; r++) begin
      state_i = s;
      round_i = 4'(r);
      en_i    = 1'b1;
      step();
      checks++;
      if (state_o[2] !== {56'h0, exp_c[r]}) begin
        failures++;
        $display("[TB] FAIL sweep_r%0d got=%h want=%h", r, state_o[2], {56'h0, exp_c[r]});
      end
      checks++;
      if (state_o[4] !== base[4] || state_o[0] !== base[0]) begin
        failures++;
        $display("[TB] FAIL sweep_passthru_r%0d got=%h/%h want=%h/%h",
                 r, state_o[0], state_o[4], base[0], base[4]);
      end
      if (r == 6) begin
        #2 resetb_i = 1'b0;
        #1;
        checks++;
        if (state_o !== '0) begin
          failures++;
          $display("[TB] FAIL sweep_async_reset got=%h want=0", state_o);
        end
        @(negedge clock_i);
        resetb_i = 1'b1;
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    base[0]  = 64'h80400c0600000000;
    base[1]  = 64'h8a55114d1cb6a9a2;
    base[2]  = 64'hbe263d4d7aecaaff;
    base[3]  = 64'h4ed0ec0b98c529b7;
    base[4]  = 64'hc8cddf37bcd0284a;
    resetb_i = 1'b0;
    en_i     = 1'b0;
    round_i  = 4'd0;
    state_i  = '0;
    @(negedge clock_i);

    test_reset();
    test_rounds();
    test_out_of_range();
    test_enable_hold();
    test_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/constant_addition.md
Name: constant_addition

Overview:
- Ascon-128 permutation layer p_C: XORs the round constant c_r into the least-significant byte of state word x2.
- Registered variant: result is captured on the clock edge.
- Sits in the permutation datapath ahead of the substitution layer, driven by the round counter.
- All other state words pass through unmodified.

Parameters:
- none. Widths come from ascon_pack: state is 5 x 64 bits, round index is 4 bits.

Ports:
- clock_i  input  1  system clock, rising-edge active
- resetb_i  input  1  asynchronous, active-low reset
- en_i  input  1  capture enable; a new result is registered only when high
- round_i  input  4  round index 0..15 selecting the constant
- state_i  input  type_state (5x64)  input state x0..x4
- state_o  output  type_state (5x64)  registered output state

Behaviour:
- Reset:
  - resetb_i low forces state_o to all-zero (all five words) immediately, without waiting for a clock edge.
  - Reset dominates en_i.
- Combinational core, for each word k:
  - k != 2: next[k] = state_i[k].
  - k = 2: next[2] = state_i[2] XOR {56'h0, c(round_i)}.
- Constant table c(r), 8 bits, indexed by round_i:
  - 0:F0, 1:E1, 2:D2, 3:C3, 4:B4, 5:A5, 6:96, 7:87, 8:78, 9:69, 10:5A, 11:4B.
  - Rule: c(r) = {(4'hF - r), r} for r in 0..11.
- round_i 12..15 select constant 8'h00, so the state passes through unchanged. No error flag.
- Register:
  - Rising edge with en_i=1: state_o <= next.
  - Rising edge with en_i=0: state_o holds its previous value.
- Latency: exactly 1 clock from state_i/round_i sampling to state_o. Throughput is 1 result per cycle when en_i is held high.
- Bit mapping: only bits [7:0] of x2 can change. Bits [63:8] of x2 and all of x0, x1, x3, x4 are bit-exact copies of the input.
- p^a uses round_i 0..11; p^b (6 rounds) uses round_i 6..11. The block is agnostic to which permutation is running.
- Reset deasserted mid-operation: the first capture occurs on the first rising edge with en_i=1 after release. No state is retained across reset.
- Inputs need only be stable around the capture edge. There is no handshake beyond en_i.

Decomposition:
- ascon_pack (shared package) holds:
  - typedef type_state: packed/unpacked array of 5 x logic[63:0], indexed 0..4 = x0..x4.
  - round-constant lookup, as a 16-entry constant array or function, with entries 12..15 = 8'h00.
  - any round-count constants, e.g. 12 for p^a and 6 for p^b.
- Sub-module: none required. The constant lookup is a package function used by constant_addition and any debug logic.

Test Plan:
- Reset: hold resetb_i=0 with arbitrary inputs -> state_o = 0 on every word, asynchronously; deassert with en_i=0 -> state_o stays 0.
- Round 0: state_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaaff, 4ed0ec0b98c529b7, c8cddf37bcd0284a}, round_i=0, en_i=1, one edge -> x2 = be263d4d7aecaa0f, all other words equal to input.
- Rounds 6 and 11, same state: round_i=6 -> x2 = be263d4d7aecaa69; round_i=11 -> x2 = be263d4d7aecaab4.
- Out-of-range rounds: round_i=12 and round_i=15 -> state_o equals state_i exactly.
- Enable hold: after the round 0 capture, change state_i and set round_i=3 with en_i=0 for 3 edges -> state_o unchanged (x2 = ...aa0f). Raising en_i -> capture on the next edge.
- Sweep: round_i 0..11 on consecutive enabled cycles with x2 = 0 -> x2 output sequence F0, E1, D2, C3, B4, A5, 96, 87, 78, 69, 5A, 4B, each one cycle after its input. Assert async reset mid-sweep -> immediate zeros.
